// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle fetch/decode/execute sequencer issuing ALU opcodes,
// register-file selects/writeback and data-memory requests for a 9-bit ISA.
module seq_ctrl #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned INST_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              done_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              imem_req_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [2:0]        rs_sel_o,
  output logic [2:0]        rt_sel_o,
  input  logic [7:0]        rs_val_i,
  output logic [3:0]        alu_op_o,
  output logic              cf_o,
  input  logic              alu_ov_i,
  input  logic              alu_z_i,
  output logic              rf_we_o,
  output logic              wb_sel_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  input  logic              dmem_ack_i
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SEL_W = 3;

  localparam logic [OP_W-1:0] OP_CLR = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_LD  = 4'd5;
  localparam logic [OP_W-1:0] OP_ST  = 4'd6;
  localparam logic [OP_W-1:0] OP_SL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SR  = 4'd8;
  localparam logic [OP_W-1:0] OP_SET = 4'd9;
  localparam logic [OP_W-1:0] OP_BZ  = 4'd10;
  localparam logic [OP_W-1:0] OP_BNZ = 4'd11;
  localparam logic [OP_W-1:0] OP_INC = 4'd12;
  localparam logic [OP_W-1:0] OP_DEC = 4'd13;
  localparam logic [OP_W-1:0] OP_JMP = 4'd14;
  localparam logic [OP_W-1:0] OP_ADC = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic                r_cf;
  logic                r_done;
  logic                r_imem_req;
  logic                r_dmem_req;
  logic                r_dmem_we;
  logic [INST_W-1:0]   r_inst;
  logic [OP_W-1:0]     r_alu_op;
  logic [SEL_W-1:0]    r_rs_sel;
  logic [SEL_W-1:0]    r_rt_sel;

  logic                w_writes;
  logic                w_cf_upd;
  logic                w_is_ld;
  logic [PC_W-1:0]     w_pc_inc;
  logic [PC_W-1:0]     w_target;
  logic                w_jmp_self;
  logic                w_rf_we;
  logic                w_wb_sel;

  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_target   = PC_W'(rs_val_i);
  assign w_jmp_self = (w_target == r_pc);
  assign w_is_ld    = (r_alu_op == OP_LD);

  // Classify the decoded opcode: ALU writeback and carry-flag update
  always_comb begin
    w_writes = 1'b0;
    w_cf_upd = 1'b0;
    case (r_alu_op)
      OP_CLR, OP_AND, OP_OR, OP_SL, OP_SR, OP_SET: w_writes = 1'b1;
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC: begin
        w_writes = 1'b1;
        w_cf_upd = 1'b1;
      end
      default: begin
        w_writes = 1'b0;
        w_cf_upd = 1'b0;
      end
    endcase
  end

  // Writeback strobe: one cycle in EXEC for ALU ops, or the ack cycle of a load
  always_comb begin
    w_rf_we  = 1'b0;
    w_wb_sel = 1'b0;
    if (r_state == S_EXEC && w_writes) begin
      w_rf_we = 1'b1;
    end else if (r_state == S_MEM && w_is_ld && dmem_ack_i) begin
      w_rf_we  = 1'b1;
      w_wb_sel = 1'b1;
    end
  end

  // Sequencer FSM with registered request, flag and select outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_cf       <= 1'b0;
      r_done     <= 1'b0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_inst     <= '0;
      r_alu_op   <= '0;
      r_rs_sel   <= '0;
      r_rt_sel   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_pc       <= '0;
            r_cf       <= 1'b0;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (imem_ack_i) begin
            r_inst     <= inst_i;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end

        S_DECODE: begin
          r_alu_op <= r_inst[8:5];
          r_rs_sel <= r_inst[4:2];
          r_rt_sel <= {1'b0, r_inst[1:0]};
          r_state  <= S_EXEC;
        end

        S_EXEC: begin
          case (r_alu_op)
            OP_LD, OP_ST: begin
              r_dmem_req <= 1'b1;
              r_dmem_we  <= (r_alu_op == OP_ST);
              r_state    <= S_MEM;
            end
            OP_BZ: begin
              r_pc       <= alu_z_i ? w_target : w_pc_inc;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end
            OP_BNZ: begin
              r_pc       <= alu_z_i ? w_pc_inc : w_target;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end
            OP_JMP: begin
              if (w_jmp_self) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_pc       <= w_target;
                r_imem_req <= 1'b1;
                r_state    <= S_FETCH;
              end
            end
            default: begin
              if (w_cf_upd) begin
                r_cf <= alu_ov_i;
              end
              r_pc       <= w_pc_inc;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end
          endcase
        end

        S_MEM: begin
          if (dmem_ack_i) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_pc       <= w_pc_inc;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        S_DONE: begin
          if (start_i) begin
            r_pc       <= '0;
            r_cf       <= 1'b0;
            r_done     <= 1'b0;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign done_o     = r_done;
  assign pc_o       = r_pc;
  assign imem_req_o = r_imem_req;
  assign rs_sel_o   = r_rs_sel;
  assign rt_sel_o   = r_rt_sel;
  assign alu_op_o   = r_alu_op;
  assign cf_o       = r_cf;
  assign rf_we_o    = w_rf_we;
  assign wb_sel_o   = w_wb_sel;
  assign dmem_req_o = r_dmem_req;
  assign dmem_we_o  = r_dmem_we;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: table vectors, directed multi-cycle sequences and a random
// program run against an instruction-level model of the sequencer's ISA.
module tb_seq_ctrl;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned INST_W = 9;

  localparam logic [3:0] OP_CLR = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_LD  = 4'd5,  OP_ST  = 4'd6,  OP_SL  = 4'd7;
  localparam logic [3:0] OP_SR  = 4'd8,  OP_SET = 4'd9,  OP_BZ  = 4'd10, OP_BNZ = 4'd11;
  localparam logic [3:0] OP_INC = 4'd12, OP_DEC = 4'd13, OP_JMP = 4'd14, OP_ADC = 4'd15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              done_o;
  logic [PC_W-1:0]   pc_o;
  logic              imem_req_o, imem_ack_i;
  logic [INST_W-1:0] inst_i;
  logic [2:0]        rs_sel_o, rt_sel_o;
  logic [7:0]        rs_val_i;
  logic [3:0]        alu_op_o;
  logic              cf_o, alu_ov_i, alu_z_i;
  logic              rf_we_o, wb_sel_o;
  logic              dmem_req_o, dmem_we_o, dmem_ack_i;

  logic imem_go = 1'b1;
  logic dmem_go = 1'b1;

  logic [8:0] imem [256];
  logic [7:0] regs [8];
  logic [7:0] dmem [256];
  logic [8:0] w_alu;

  int errors = 0;
  int checks = 0;
  int fcnt, wecnt;

  // instruction-level model state
  logic [7:0] m_reg [8];
  logic [7:0] m_mem [256];
  logic [7:0] m_pc;
  logic       m_cf;
  logic       m_halt;

  typedef struct {
    logic [3:0] op;
    logic [2:0] rs;
    logic [1:0] rt;
    logic [7:0] sv;
    logic [7:0] tv;
    logic [7:0] epc;
    logic       ecf;
    logic [3:0] ewe;
    logic [7:0] et;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  seq_ctrl #(.PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .done_o(done_o), .pc_o(pc_o),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .inst_i(inst_i),
    .rs_sel_o(rs_sel_o), .rt_sel_o(rt_sel_o), .rs_val_i(rs_val_i),
    .alu_op_o(alu_op_o), .cf_o(cf_o), .alu_ov_i(alu_ov_i), .alu_z_i(alu_z_i),
    .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i)
  );

  always #5 clk = ~clk;

  // external ALU: result in [7:0], carry/borrow out in [8]
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] s,
                                       input logic [7:0] t, input logic cin);
    case (op)
      OP_ADD:  return {1'b0, s} + {1'b0, t};
      OP_SUB:  return {1'b0, s} - {1'b0, t};
      OP_AND:  return {1'b0, s & t};
      OP_OR:   return {1'b0, s | t};
      OP_SL:   return {t, 1'b0};
      OP_SR:   return {2'b00, t[7:1]};
      OP_SET:  return 9'h0FF;
      OP_INC:  return {1'b0, t} + 9'd1;
      OP_DEC:  return {1'b0, t} - 9'd1;
      OP_ADC:  return {1'b0, s} + {1'b0, t} + {8'd0, cin};
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [2:0] rs, input logic [1:0] rt);
    return {op, rs, rt};
  endfunction

  assign inst_i     = imem[pc_o];
  assign rs_val_i   = regs[rs_sel_o];
  assign w_alu      = alu_f(alu_op_o, regs[rs_sel_o], regs[rt_sel_o], cf_o);
  assign alu_ov_i   = w_alu[8];
  assign alu_z_i    = (regs[rt_sel_o] == 8'h00);
  assign imem_ack_i = imem_req_o & imem_go;
  assign dmem_ack_i = dmem_req_o & dmem_go;

  // register file and data memory behind the sequencer
  always @(posedge clk) begin
    if (rf_we_o) regs[rt_sel_o] <= wb_sel_o ? dmem[rs_val_i] : w_alu[7:0];
    if (dmem_req_o && dmem_ack_i && dmem_we_o) dmem[rs_val_i] <= regs[rt_sel_o];
  end

  // fetch and writeback event counters
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt  <= 0;
      wecnt <= 0;
    end else begin
      if (imem_req_o && imem_ack_i) fcnt <= fcnt + 1;
      if (rf_we_o) wecnt <= wecnt + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start_i = 1'b0; imem_go = 1'b1; dmem_go = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_fetch(input int n, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (fcnt == n && imem_req_o) ok = 1'b1;
    end
    check({nm, "_reached"}, 32'(ok), 1);
  endtask

  task automatic m_step(input logic [8:0] ins);
    logic [3:0] op; logic [2:0] rs, rt; logic [7:0] s, t; logic [8:0] r;
    op = ins[8:5]; rs = ins[4:2]; rt = {1'b0, ins[1:0]};
    s = m_reg[rs]; t = m_reg[rt]; r = alu_f(op, s, t, m_cf);
    case (op)
      OP_LD:  begin m_reg[rt] = m_mem[s]; m_pc = m_pc + 8'd1; end
      OP_ST:  begin m_mem[s] = t; m_pc = m_pc + 8'd1; end
      OP_BZ:  m_pc = (t == 8'h00) ? s : m_pc + 8'd1;
      OP_BNZ: m_pc = (t != 8'h00) ? s : m_pc + 8'd1;
      OP_JMP: if (s == m_pc) m_halt = 1'b1; else m_pc = s;
      default: begin
        m_reg[rt] = r[7:0];
        if (op == OP_ADD || op == OP_SUB || op == OP_INC || op == OP_DEC || op == OP_ADC)
          m_cf = r[8];
        m_pc = m_pc + 8'd1;
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hw, nhalts, diffs;
    //          op      rs    rt    sv     tv     epc    ecf   we    et
    vt[0]  = '{OP_ADD, 3'd0, 2'd1, 8'h20, 8'hF0, 8'h01, 1'b1, 4'd1, 8'h10};
    vt[1]  = '{OP_SUB, 3'd2, 2'd1, 8'h10, 8'h30, 8'h01, 1'b1, 4'd1, 8'hE0};
    vt[2]  = '{OP_AND, 3'd2, 2'd3, 8'hF0, 8'h3C, 8'h01, 1'b0, 4'd1, 8'h30};
    vt[3]  = '{OP_OR,  3'd4, 2'd0, 8'h0F, 8'h30, 8'h01, 1'b0, 4'd1, 8'h3F};
    vt[4]  = '{OP_SL,  3'd0, 2'd1, 8'h00, 8'h81, 8'h01, 1'b0, 4'd1, 8'h02};
    vt[5]  = '{OP_SR,  3'd0, 2'd1, 8'h00, 8'h81, 8'h01, 1'b0, 4'd1, 8'h40};
    vt[6]  = '{OP_SET, 3'd0, 2'd2, 8'h00, 8'h12, 8'h01, 1'b0, 4'd1, 8'hFF};
    vt[7]  = '{OP_CLR, 3'd0, 2'd3, 8'h00, 8'h55, 8'h01, 1'b0, 4'd1, 8'h00};
    vt[8]  = '{OP_INC, 3'd0, 2'd1, 8'h00, 8'hFF, 8'h01, 1'b1, 4'd1, 8'h00};
    vt[9]  = '{OP_DEC, 3'd0, 2'd2, 8'h00, 8'h00, 8'h01, 1'b1, 4'd1, 8'hFF};
    vt[10] = '{OP_BZ,  3'd5, 2'd2, 8'h40, 8'h00, 8'h40, 1'b0, 4'd0, 8'h00};
    vt[11] = '{OP_BNZ, 3'd5, 2'd2, 8'h40, 8'h00, 8'h01, 1'b0, 4'd0, 8'h00};
    vt[12] = '{OP_BNZ, 3'd5, 2'd2, 8'h40, 8'h07, 8'h40, 1'b0, 4'd0, 8'h07};
    vt[13] = '{OP_JMP, 3'd6, 2'd0, 8'h33, 8'h11, 8'h33, 1'b0, 4'd0, 8'h11};
    vt[14] = '{OP_ADC, 3'd1, 2'd2, 8'h01, 8'h02, 8'h01, 1'b0, 4'd1, 8'h03};
    vt[15] = '{OP_ST,  3'd1, 2'd2, 8'h90, 8'h5A, 8'h01, 1'b0, 4'd0, 8'h5A};

    for (int i = 0; i < 256; i++) begin imem[i] = 9'h000; dmem[i] <= 8'h00; end
    for (int i = 0; i < 8; i++) regs[i] <= 8'h00;

    // reset values
    do_reset();
    check("rst_pc", pc_o, 0);        check("rst_cf", cf_o, 0);
    check("rst_done", done_o, 0);    check("rst_imem_req", imem_req_o, 0);
    check("rst_dmem_req", dmem_req_o, 0); check("rst_rf_we", rf_we_o, 0);
    check("rst_alu_op", alu_op_o, 0); check("rst_rt_sel", rt_sel_o, 0);
    repeat (3) @(negedge clk);
    check("idle_no_fetch", imem_req_o, 0);

    // single-instruction table
    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int i = 0; i < 8; i++) regs[i] <= 8'($urandom);
      regs[vt[v].rs] <= vt[v].sv;
      regs[{1'b0, vt[v].rt}] <= vt[v].tv;
      imem[0] = mk(vt[v].op, vt[v].rs, vt[v].rt);
      start_i = 1'b1; @(negedge clk); start_i = 1'b0;
      wait_fetch(1, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_pc", v), pc_o, vt[v].epc);
      check($sformatf("vec%0d_cf", v), cf_o, vt[v].ecf);
      check($sformatf("vec%0d_rt", v), regs[{1'b0, vt[v].rt}], vt[v].et);
      check($sformatf("vec%0d_we", v), wecnt, vt[v].ewe);
    end

    // reset in the middle of a stalled fetch
    do_reset();
    regs[0] <= 8'h20; regs[1] <= 8'hF0;
    imem[0] = mk(OP_ADD, 3'd0, 2'd1);
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    wait_fetch(1, "mrst");
    imem_go = 1'b0;
    @(negedge clk);
    check("mrst_req_before", imem_req_o, 1); check("mrst_pc_before", pc_o, 1);
    check("mrst_cf_before", cf_o, 1);
    #2 rst = 1'b1;
    #1;
    check("mrst_req", imem_req_o, 0); check("mrst_pc", pc_o, 0); check("mrst_cf", cf_o, 0);
    @(negedge clk); rst = 1'b0; imem_go = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_idle", imem_req_o, 0);

    // ADD / AND / ADC with cycle-level writeback timing; start_i held high
    do_reset();
    regs[0] <= 8'h20; regs[1] <= 8'hF0; regs[2] <= 8'h05; regs[3] <= 8'hFF; regs[4] <= 8'h10;
    imem[0] = mk(OP_ADD, 3'd0, 2'd1);
    imem[1] = mk(OP_AND, 3'd4, 2'd3);
    imem[2] = mk(OP_ADC, 3'd4, 2'd2);
    start_i = 1'b1;
    @(negedge clk);
    check("seq_c1_req", imem_req_o, 1); check("seq_c1_we", rf_we_o, 0);
    @(negedge clk);
    check("seq_c2_we", rf_we_o, 0);
    @(negedge clk);
    check("seq_c3_we", rf_we_o, 1); check("seq_c3_wbsel", wb_sel_o, 0);
    check("seq_c3_op", alu_op_o, OP_ADD);
    @(negedge clk);
    check("seq_add_pc", pc_o, 1); check("seq_add_cf", cf_o, 1);
    check("seq_add_r1", regs[1], 8'h10); check("seq_c4_we", rf_we_o, 0);
    wait_fetch(2, "seq_and");
    check("seq_and_cf", cf_o, 1); check("seq_and_r3", regs[3], 8'h10);
    wait_fetch(3, "seq_adc");
    check("seq_adc_pc", pc_o, 3); check("seq_adc_r2", regs[2], 8'h16);
    check("seq_adc_cf", cf_o, 0);
    start_i = 1'b0;

    // load with three wait cycles on the data port
    do_reset();
    regs[1] <= 8'h80; regs[2] <= 8'h00; dmem[8'h80] <= 8'hA5;
    imem[0] = mk(OP_LD, 3'd1, 2'd2);
    dmem_go = 1'b0;
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (dmem_req_o) seen = 1'b1; else @(negedge clk);
      end
      check("ld_req_seen", 32'(seen), 1);
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ld_wait%0d_req", k), dmem_req_o, 1);
      check($sformatf("ld_wait%0d_we", k), {dmem_we_o, rf_we_o}, 2'b00);
      @(negedge clk);
    end
    dmem_go = 1'b1;
    #1;
    check("ld_ack_req", dmem_req_o, 1); check("ld_ack_dwe", dmem_we_o, 0);
    check("ld_ack_rfwe", rf_we_o, 1);   check("ld_ack_wbsel", wb_sel_o, 1);
    @(negedge clk);
    check("ld_after_req", dmem_req_o, 0); check("ld_after_pc", pc_o, 1);
    check("ld_after_r2", regs[2], 8'hA5); check("ld_after_we", rf_we_o, 0);

    // JMP to own address halts; start restarts from zero
    do_reset();
    regs[0] <= 8'hF0; regs[2] <= 8'h20; regs[1] <= 8'h07;
    imem[0] = mk(OP_ADD, 3'd0, 2'd2);
    imem[1] = mk(OP_JMP, 3'd1, 2'd0);
    imem[7] = mk(OP_JMP, 3'd1, 2'd0);
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (done_o) seen = 1'b1;
      end
      check("halt_done", 32'(seen), 1);
    end
    check("halt_pc", pc_o, 8'h07); check("halt_cf", cf_o, 1); check("halt_req", imem_req_o, 0);
    repeat (2) @(negedge clk);
    check("halt_hold_done", done_o, 1); check("halt_hold_pc", pc_o, 8'h07);
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    check("restart_pc", pc_o, 0); check("restart_cf", cf_o, 0);
    check("restart_done", done_o, 0); check("restart_req", imem_req_o, 1);

    // pc wraps from 0xFF to 0x00
    do_reset();
    regs[1] <= 8'hFF;
    imem[0]     = mk(OP_JMP, 3'd1, 2'd0);
    imem[8'hFF] = mk(OP_SET, 3'd0, 2'd3);
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    wait_fetch(1, "wrap_a");
    check("wrap_pc_ff", pc_o, 8'hFF);
    wait_fetch(2, "wrap_b");
    check("wrap_pc_00", pc_o, 8'h00); check("wrap_r3", regs[3], 8'hFF);

    // random programs with random memory latency against the ISA model
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [8:0] ins;
      logic [7:0] d;
      ins = 9'($urandom);
      if ((ins[8:5] == OP_BZ || ins[8:5] == OP_BNZ || ins[8:5] == OP_JMP) && $urandom_range(3) != 0)
        ins[8:5] = OP_ADD;
      imem[i] = ins;
      d = 8'($urandom);
      dmem[i] <= d; m_mem[i] = d;
    end
    imem[8'h10] = mk(OP_JMP, 3'd7, 2'd0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = (i == 7) ? 8'h10 : 8'($urandom);
      regs[i] <= d; m_reg[i] = d;
    end
    m_pc = 8'h00; m_cf = 1'b0; m_halt = 1'b0;
    hw = 0; nhalts = 0;
    start_i = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      imem_go = ($urandom_range(3) != 0);
      dmem_go = ($urandom_range(2) != 0);
      start_i = 1'b0;
      if (done_o) begin
        check("rnd_halt", m_halt, 1); check("rnd_halt_pc", pc_o, m_pc);
        start_i = 1'b1; m_pc = 8'h00; m_cf = 1'b0; m_halt = 1'b0; hw = 0; nhalts++;
      end else begin
        if (imem_req_o && imem_go) begin
          check("rnd_fetch_pc", pc_o, m_pc); check("rnd_fetch_cf", cf_o, m_cf);
          check("rnd_fetch_running", m_halt, 0);
          m_step(imem[pc_o]);
        end
        if (m_halt) begin
          hw++;
          if (hw > 8) begin check("rnd_halt_timeout", done_o, 1); hw = 0; end
        end
        start_i = ($urandom_range(15) == 0);
      end
    end
    @(negedge clk);
    start_i = 1'b0; imem_go = 1'b0; dmem_go = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) check($sformatf("rnd_reg%0d", i), regs[i], m_reg[i]);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== m_mem[i]) diffs++;
    check("rnd_dmem_diffs", diffs, 0);
    check("rnd_halts_seen", 32'(nhalts > 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
- Multi-cycle control sequencer; it is the issuing end of the ALU opcode interface.
- Fetches 9-bit instructions from instruction memory and decodes them.
- Drives register-file selects, ALU opcode and carry-in, register writeback and data-memory requests.
- Consumes the ALU zero and carry flags for branches and for the carry-flag register.

Parameters:
PC_W, 8, program-counter and branch-target width
INST_W, 9, instruction width; field layout fixed: op=inst[8:5], rs=inst[4:2], rt={1'b0,inst[1:0]}

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  begin execution from pc 0
done_o  out  1  program halted
pc_o  out  PC_W  instruction address
imem_req_o  out  1  instruction fetch request
imem_ack_i  in  1  fetch complete; inst_i valid this cycle
inst_i  in  INST_W  fetched instruction
rs_sel_o  out  3  register-file read select, operand s
rt_sel_o  out  3  register-file read select, operand t
rs_val_i  in  8  register value of rs_sel_o (combinational read)
alu_op_o  out  4  opcode to ALU
cf_o  out  1  carry-flag register, drives ALU carry-in
alu_ov_i  in  1  ALU carry-out
alu_z_i  in  1  ALU zero flag (operand t == 0)
rf_we_o  out  1  register write enable; destination is rt_sel_o
wb_sel_o  out  1  0 = ALU result, 1 = dmem_rdata
dmem_req_o  out  1  data-memory request; address = rs_val_i, wdata = rt register
dmem_we_o  out  1  1 = store, 0 = load
dmem_ack_i  in  1  data access complete

Behaviour:
- Opcodes: CLR0 ADD1 SUB2 AND3 OR4 LD5 ST6 SL7 SR8 SET9 BZ10 BNZ11 INC12 DEC13 JMP14 ADC15.
- Reset (async): state=IDLE; pc_o=0; cf_o=0; done_o=0; all req/we outputs 0; selects and alu_op_o 0. Reset mid-access drops requests immediately.
- States: IDLE, FETCH, DECODE, EXEC, MEM, DONE.
- IDLE: start_i -> FETCH.
- FETCH:
  - imem_req_o=1 with pc_o stable until imem_ack_i.
  - On ack, latch inst_i -> DECODE.
  - Ack is sampled in any FETCH cycle, including the first.
- DECODE: register op/rs/rt onto alu_op_o/rs_sel_o/rt_sel_o; these hold until the next DECODE. -> EXEC.
- EXEC (one cycle, ALU combinational):
  - CLR/ADD/SUB/AND/OR/SL/SR/SET/INC/DEC/ADC: rf_we_o=1, wb_sel_o=0, pc+1, -> FETCH.
  - ADD/SUB/INC/DEC/ADC additionally load cf_o <= alu_ov_i at end of EXEC. All other ops preserve cf_o.
  - BZ: if alu_z_i, pc <= rs_val_i, else pc+1. BNZ: inverse. -> FETCH.
  - JMP: if rs_val_i == pc_o -> DONE (halt, pc unchanged); else pc <= rs_val_i -> FETCH.
  - LD/ST: -> MEM.
- MEM:
  - dmem_req_o=1 held until dmem_ack_i; dmem_we_o=1 for ST.
  - LD: on ack, rf_we_o=1 and wb_sel_o=1 in that same cycle.
  - On ack: pc+1 -> FETCH.
- DONE: done_o=1; start_i -> FETCH with pc=0 and cf=0, done_o cleared.
- start_i is ignored outside IDLE/DONE.
- pc increment wraps modulo 2^PC_W (0xFF+1 -> 0x00).
- rf_we_o asserts for exactly one cycle per writing instruction; never asserts in FETCH or DECODE.
- Latency with zero-wait memories: 3 cycles per non-memory instruction, 4 per LD/ST.

Test Plan:
- Reset mid-FETCH with imem_req_o=1 -> same cycle req=0, pc_o=0, cf_o=0; IDLE until start_i.
- Program ADD r1,r0 with r1=0xF0, r0=0x20, ack on first cycle -> rf_we_o pulses in cycle 3; cf_o=1 after EXEC; pc_o=1.
- Follow with AND -> cf_o stays 1; ADC r2 with r2=0x05 -> ALU sees carry-in 1, cf_o updated from alu_ov_i.
- BZ with alu_z_i=1, rs_val_i=0x40 -> pc_o=0x40; BNZ with same inputs -> pc_o=old+1.
- LD, dmem_ack_i delayed 3 cycles -> dmem_req_o held 4 cycles, dmem_we_o=0, rf_we_o=1 and wb_sel_o=1 only in the ack cycle.
- JMP to own address 0x07 -> done_o=1 and pc_o stays 0x07.
- Then start_i -> pc_o=0, cf_o=0 and fetch resumes.
- pc_o=0xFF with a non-branch instruction -> next pc_o=0x00.
